axi_lite_top: RTL and testbench
===============================

Name: axi_lite_top

Overview:
- Self-contained AXI4-Lite loopback block.
- An internal AXI4-Lite master converts simple external write/read requests into AXI4-Lite transactions.
- Those transactions go to an internal AXI4-Lite slave fronting a 2^ADDR_WIDTH x DATA_WIDTH register memory.
- Used as a protocol demonstrator and integration fixture; the AXI channels are internal only.

Parameters:
- DATA_WIDTH, 8, width of data bus and of each memory word.
- ADDR_WIDTH, 7, width of word address; memory depth 2^ADDR_WIDTH (128).

Ports:
- ACLK  in  1  system clock, rising edge.
- ARESET_N  in  1  asynchronous, active-high reset. 1 = reset, despite the suffix.
- write_request  in  1  level request: start a write whenever the write engine is idle.
- read_request  in  1  level request: start a read whenever the read engine is idle.
- ext_waddr  in  ADDR_WIDTH  write word address, sampled at write start.
- ext_raddr  in  ADDR_WIDTH  read word address, sampled at read start.
- ext_wdata  in  DATA_WIDTH  write data, sampled at write start.
- ext_rdata  out  DATA_WIDTH  data of the last completed read; held between reads.

Behaviour:
- Reset (asynchronous, while ARESET_N=1):
  - all FSMs go to IDLE; all VALID/READY signals = 0.
  - ext_rdata = 0; internal BRESP/RRESP = 0 (OKAY).
  - all memory words = 0.
- Inputs are sampled only at rising ACLK edges. Changes between edges are ignored.
- Write and read engines are independent and may run concurrently.
- Master write FSM, states W_IDLE -> W_ADDR -> W_RESP -> W_IDLE:
  - W_IDLE: at an edge with write_request=1, latch ext_waddr/ext_wdata into AWADDR/WDATA; AWVALID=WVALID=1; go W_ADDR.
  - W_ADDR: hold AWVALID/WVALID and their payloads until the edge where AWREADY&WREADY; then drop both, BREADY=1, go W_RESP.
  - W_RESP: at the edge with BVALID&BREADY, BREADY=0, go W_IDLE.
- Master read FSM, states R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE: at an edge with read_request=1, latch ext_raddr; ARVALID=1; go R_ADDR.
  - R_ADDR: at the ARVALID&ARREADY edge, ARVALID=0, RREADY=1, go R_DATA.
  - R_DATA: at the RVALID&RREADY edge, ext_rdata<=RDATA, RREADY=0, go R_IDLE.
- Slave write side:
  - AWREADY/WREADY are registered. Both go 1 for exactly one cycle at the edge after AWVALID&WVALID are seen with BVALID=0.
  - At the handshake edge: mem[AWADDR]<=WDATA, BVALID=1, BRESP=OKAY.
  - BVALID clears at the BREADY edge.
- Slave read side:
  - ARREADY is registered. It pulses for one cycle after ARVALID is seen with RVALID=0.
  - At the handshake edge: RDATA<=mem[ARADDR], RVALID=1, RRESP=OKAY.
  - RVALID clears at the RREADY edge.
- Timing (edge 0 = the edge that accepts the request):
  - Write: READY pulse at edge 1, memory update at edge 2, B handshake at edge 3. Engine idle after edge 3; next capture at edge 4. Back-to-back writes every 4 cycles while write_request stays high.
  - Read: ARREADY at edge 1, RDATA captured at edge 2, ext_rdata updated at edge 3. Next capture at edge 4.
- A request deasserted mid-transaction does not abort it. The transaction completes; no new one starts.
- A new address or data value presented during a transaction is ignored.
- A read and a write to the same address with memory update and read capture on the same edge: the read returns the old value.
- Address width exactly covers the memory, so there is no out-of-range case. All responses are OKAY.
- Reset asserted mid-transaction: immediate return to the reset state; memory is cleared.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY (2'b00).
  - Write FSM enum (W_IDLE, W_ADDR, W_RESP).
  - Read FSM enum (R_IDLE, R_ADDR, R_DATA).
- Sub-module axi_lite_slave: the slave handshake logic plus the memory array, connected to the master logic in the top over the five AXI4-Lite channels.

Test Plan:
- Reset: hold ARESET_N=1 for 2 cycles -> ext_rdata=0, all VALIDs 0. A read of address 0x05 afterwards returns 0x00.
- Single write then read: write addr 0x10 data 0xA5, then read addr 0x10 -> memory updated at edge 2 of the write; ext_rdata=0xA5 at edge 3 of the read.
- Held request: write_request high for 12 cycles, ext_waddr incrementing every cycle -> exactly 3 writes. Addresses are the values present at the capture edges 0, 4 and 8.
- Concurrent: write 0x7F<-0x3C and read 0x00 issued on the same edge -> both complete in 4 cycles; ext_rdata = previous mem[0x00].
- Same-address collision: mem[0x20]=0x11, write 0x20<-0x22 and read 0x20 started on the same edge -> ext_rdata=0x11; a later read returns 0x22.
- Mid-transaction reset: assert ARESET_N during W_ADDR -> FSMs return to IDLE, memory reads back 0, and no B handshake occurs.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared constants and state encodings for the AXI4-Lite loopback fixture.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

endpackage

// File: rtl/axi_lite_if.sv
// The five AXI4-Lite channels between the internal master and slave.
interface axi_lite_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave.sv
// AXI4-Lite slave with registered one-cycle READY pulses fronting a
// 2^ADDR_WIDTH-word register memory that is cleared by reset.
module axi_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  axi_lite_if.slave  s_axi
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_awready, r_wready, r_bvalid;
  logic                  r_arready, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_aw_hs, w_ar_hs;

  assign w_aw_hs = s_axi.awvalid & s_axi.awready & s_axi.wvalid & s_axi.wready;
  assign w_ar_hs = s_axi.arvalid & s_axi.arready;

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = r_rdata;

  // READY is withheld while the previous response is outstanding and
  // dropped at the handshake edge so it is never high for two cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_mem     <= '{default: '0};
    end else if (w_aw_hs) begin
      r_awready           <= 1'b0;
      r_wready            <= 1'b0;
      r_mem[s_axi.awaddr] <= s_axi.wdata;
      r_bvalid            <= 1'b1;
      r_bresp             <= RESP_OKAY;
    end else begin
      if (s_axi.awvalid && s_axi.wvalid && !r_bvalid && !r_awready) begin
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
      if (r_bvalid && s_axi.bready) r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else if (w_ar_hs) begin
      r_arready <= 1'b0;
      r_rdata   <= r_mem[s_axi.araddr];
      r_rvalid  <= 1'b1;
      r_rresp   <= RESP_OKAY;
    end else begin
      if (s_axi.arvalid && !r_rvalid && !r_arready) r_arready <= 1'b1;
      if (r_rvalid && s_axi.rready) r_rvalid <= 1'b0;
    end
  end
endmodule

// File: rtl/axi_lite_top.sv
// AXI4-Lite loopback: level-request write/read master engines driving the
// internal slave memory. ARESET_N is active-high despite its name.
module axi_lite_top
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  ACLK,
  input  logic                  ARESET_N,
  input  logic                  write_request,
  input  logic                  read_request,
  input  logic [ADDR_WIDTH-1:0] ext_waddr,
  input  logic [ADDR_WIDTH-1:0] ext_raddr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic [DATA_WIDTH-1:0] ext_rdata
);
  axi_lite_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) axi ();

  wstate_t               r_wstate;
  rstate_t               r_rstate;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0] r_wdata, r_ext_rdata;
  logic                  r_awvalid, r_wvalid, r_bready;
  logic                  r_arvalid, r_rready;

  assign axi.awaddr  = r_awaddr;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;
  assign axi.araddr  = r_araddr;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;
  assign ext_rdata   = r_ext_rdata;

  // A non-OKAY write response replays the held address/data.
  always_ff @(posedge ACLK or posedge ARESET_N) begin
    if (ARESET_N) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (write_request) begin
          r_awaddr  <= ext_waddr;
          r_wdata   <= ext_wdata;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_wstate  <= W_ADDR;
        end
        W_ADDR: if (axi.awready && axi.wready) begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b1;
          r_wstate  <= W_RESP;
        end
        W_RESP: if (axi.bvalid && r_bready) begin
          r_bready <= 1'b0;
          if (axi.bresp == RESP_OKAY) begin
            r_wstate <= W_IDLE;
          end else begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_wstate  <= W_ADDR;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET_N) begin
    if (ARESET_N) begin
      r_rstate    <= R_IDLE;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_ext_rdata <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (read_request) begin
          r_araddr  <= ext_raddr;
          r_arvalid <= 1'b1;
          r_rstate  <= R_ADDR;
        end
        R_ADDR: if (r_arvalid && axi.arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_rstate  <= R_DATA;
        end
        R_DATA: if (axi.rvalid && r_rready) begin
          r_ext_rdata <= (axi.rresp == RESP_OKAY) ? axi.rdata : '0;
          r_rready    <= 1'b0;
          r_rstate    <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  axi_lite_slave #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slave (
    .i_clk (ACLK),
    .i_rst (ARESET_N),
    .s_axi (axi.slave)
  );
endmodule

// File: tb/tb_axi_lite_top.sv
// Directed bench for axi_lite_top: reset, write/read timing, held request,
// concurrent and same-address traffic, and reset during a write.
module tb_axi_lite_top;
  localparam int DW = 8;
  localparam int AW = 7;

  logic          ACLK = 1'b0;
  logic          ARESET_N;
  logic          write_request, read_request;
  logic [AW-1:0] ext_waddr, ext_raddr;
  logic [DW-1:0] ext_wdata, ext_rdata;

  int n_cmp = 0;
  int n_fail = 0;
  int n_bhs = 0;
  int hs0;

  always #5 ACLK = ~ACLK;

  axi_lite_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK          (ACLK),
    .ARESET_N      (ARESET_N),
    .write_request (write_request),
    .read_request  (read_request),
    .ext_waddr     (ext_waddr),
    .ext_raddr     (ext_raddr),
    .ext_wdata     (ext_wdata),
    .ext_rdata     (ext_rdata)
  );

  always @(posedge ACLK)
    if (dut.axi.bvalid === 1'b1 && dut.axi.bready === 1'b1) n_bhs++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_request = 1'b1;
    ext_waddr     = a;
    ext_wdata     = d;
    tick(1);
    write_request = 1'b0;
    tick(3);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    read_request = 1'b1;
    ext_raddr    = a;
    tick(1);
    read_request = 1'b0;
    tick(3);
    check(tag, ext_rdata, exp);
  endtask

  initial begin
    ARESET_N      = 1'b1;
    write_request = 1'b0;
    read_request  = 1'b0;
    ext_waddr     = '0;
    ext_raddr     = '0;
    ext_wdata     = '0;
    tick(2);
    check("rst_rdata", ext_rdata, 0);
    check("rst_valids", {dut.axi.awvalid, dut.axi.wvalid, dut.axi.bvalid,
                         dut.axi.arvalid, dut.axi.rvalid}, 0);
    ARESET_N = 1'b0;
    tick(1);
    do_read(7'h05, 8'h00, "rst_read05");

    // single write with per-edge timing
    write_request = 1'b1;
    ext_waddr     = 7'h10;
    ext_wdata     = 8'hA5;
    tick(1);
    write_request = 1'b0;
    ext_waddr     = 7'h11;
    ext_wdata     = 8'hFF;
    check("w_e0_valid", {dut.axi.awvalid, dut.axi.wvalid}, 2'b11);
    tick(1);
    check("w_e1_ready", {dut.axi.awready, dut.axi.wready}, 2'b11);
    check("w_e1_mem", dut.u_slave.r_mem[7'h10], 8'h00);
    tick(1);
    check("w_e2_mem", dut.u_slave.r_mem[7'h10], 8'hA5);
    check("w_e2_bvalid", {dut.axi.bvalid, dut.axi.bready, dut.axi.awready}, 3'b110);
    tick(1);
    check("w_e3_idle", {dut.axi.bvalid, dut.axi.bready, dut.axi.awvalid}, 3'b000);
    check("w_no_stray", dut.u_slave.r_mem[7'h11], 8'h00);

    // single read with per-edge timing
    read_request = 1'b1;
    ext_raddr    = 7'h10;
    tick(1);
    read_request = 1'b0;
    ext_raddr    = 7'h05;
    check("r_e0_arvalid", dut.axi.arvalid, 1'b1);
    tick(1);
    check("r_e1_arready", dut.axi.arready, 1'b1);
    tick(1);
    check("r_e2_rvalid", {dut.axi.rvalid, dut.axi.rready, dut.axi.arvalid}, 3'b110);
    check("r_e2_hold", ext_rdata, 8'h00);
    tick(1);
    check("r_e3_rdata", ext_rdata, 8'hA5);

    // held write request: captures at edges 0, 4, 8
    hs0 = n_bhs;
    write_request = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ext_waddr = 7'(7'h40 + i);
      ext_wdata = 8'(8'h80 + i);
      tick(1);
    end
    write_request = 1'b0;
    tick(2);
    check("held_count", n_bhs - hs0, 3);
    check("held_m40", dut.u_slave.r_mem[7'h40], 8'h80);
    check("held_m44", dut.u_slave.r_mem[7'h44], 8'h84);
    check("held_m48", dut.u_slave.r_mem[7'h48], 8'h88);
    check("held_m41", dut.u_slave.r_mem[7'h41], 8'h00);
    check("held_m4b", dut.u_slave.r_mem[7'h4B], 8'h00);

    // concurrent write and read
    do_write(7'h00, 8'h5A);
    write_request = 1'b1;
    ext_waddr     = 7'h7F;
    ext_wdata     = 8'h3C;
    read_request  = 1'b1;
    ext_raddr     = 7'h00;
    tick(1);
    write_request = 1'b0;
    read_request  = 1'b0;
    tick(3);
    check("conc_rdata", ext_rdata, 8'h5A);
    check("conc_mem7f", dut.u_slave.r_mem[7'h7F], 8'h3C);
    check("conc_idle", {dut.axi.awvalid, dut.axi.bready, dut.axi.arvalid, dut.axi.rready}, 0);
    do_read(7'h7F, 8'h3C, "conc_rb7f");

    // same-address collision returns the old value
    do_write(7'h20, 8'h11);
    write_request = 1'b1;
    ext_waddr     = 7'h20;
    ext_wdata     = 8'h22;
    read_request  = 1'b1;
    ext_raddr     = 7'h20;
    tick(1);
    write_request = 1'b0;
    read_request  = 1'b0;
    tick(3);
    check("coll_old", ext_rdata, 8'h11);
    do_read(7'h20, 8'h22, "coll_new");

    // reset while the write engine sits in W_ADDR
    write_request = 1'b1;
    ext_waddr     = 7'h30;
    ext_wdata     = 8'h77;
    tick(1);
    write_request = 1'b0;
    ARESET_N      = 1'b1;
    #1;
    check("mrst_valids", {dut.axi.awvalid, dut.axi.wvalid, dut.axi.bready}, 0);
    check("mrst_rdata", ext_rdata, 8'h00);
    check("mrst_mem20", dut.u_slave.r_mem[7'h20], 8'h00);
    tick(1);
    ARESET_N = 1'b0;
    hs0 = n_bhs;
    tick(4);
    check("mrst_no_b", n_bhs - hs0, 0);
    check("mrst_mem30", dut.u_slave.r_mem[7'h30], 8'h00);
    do_read(7'h10, 8'h00, "mrst_rd10");
    do_read(7'h20, 8'h00, "mrst_rd20");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
